// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI master arbiter.
// Provides the sequencer state enum, field widths and timer sizing.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    START,
    BUSY,
    FINISH
  } state_e;

  localparam int MODE_W = 2;
  localparam int DATA_W = 8;

  // Timer counts 0..timeout-1, so clog2 bits suffice.
  function automatic int timer_w(input int timeout);
    return $clog2(timeout);
  endfunction

endpackage

// File: rtl/spi_arbiter_rr.sv
// Combinational round-robin arbiter for any shared master.
// Ports: req_i, last_i (previous winner) -> gnt_o (one-hot), idx_o.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] last_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o
);

  localparam int IW = $clog2(N);

  int            c;
  logic [IW-1:0] ci;
  logic          found;

  // Search starts one past the last winner and wraps.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    c     = 0;
    ci    = '0;
    for (int i = 1; i <= N; i++) begin
      c  = (int'(last_i) + i) % N;
      ci = IW'(c);
      if (!found && req_i[ci]) begin
        found     = 1'b1;
        gnt_o[ci] = 1'b1;
        idx_o     = ci;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin sequencer sharing one SPI master among N_REQ requesters.
// Ports: req/req_mode/req_din in, rsp_valid/dout/err out, cs_n, m_* master side.
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [MODE_W*N_REQ-1:0] req_mode_i,
  input  logic [DATA_W*N_REQ-1:0] req_din_i,
  output logic [N_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]       rsp_dout_o,
  output logic                    rsp_err_o,
  output logic [N_REQ-1:0]        cs_n_o,
  output logic                    m_start_o,
  output logic [MODE_W-1:0]       m_mode_o,
  output logic [DATA_W-1:0]       m_din_o,
  input  logic [DATA_W-1:0]       m_dout_i,
  input  logic                    m_done_i
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = timer_w(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [IW-1:0]       last_q, last_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                err_q, err_d;
  logic [N_REQ-1:0]    cs_n_q, cs_n_d;
  logic [N_REQ-1:0]    vld_q, vld_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic [DATA_W-1:0]   din_q, din_d;

  logic [N_REQ-1:0]    win_gnt;
  logic [IW-1:0]       win_idx;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req_i  (req_i),
    .last_i (last_q),
    .gnt_o  (win_gnt),
    .idx_o  (win_idx)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    timer_d = timer_q;
    err_d   = err_q;
    cs_n_d  = cs_n_q;
    vld_d   = vld_q;
    dout_d  = dout_q;
    mode_d  = mode_q;
    din_d   = din_q;
    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          idx_d   = win_idx;
          cs_n_d  = ~win_gnt;
          mode_d  = req_mode_i[int'(win_idx)*MODE_W +: MODE_W];
          din_d   = req_din_i[int'(win_idx)*DATA_W +: DATA_W];
          state_d = SETUP;
        end
      end
      SETUP: state_d = START;
      START: begin
        timer_d = '0;
        state_d = BUSY;
      end
      BUSY: begin
        // Done takes priority over a coincident timeout.
        if (m_done_i) begin
          dout_d        = m_dout_i;
          err_d         = 1'b0;
          vld_d         = '0;
          vld_d[idx_q]  = 1'b1;
          state_d       = FINISH;
        end else if (timer_q == T_LAST) begin
          dout_d        = '0;
          err_d         = 1'b1;
          vld_d         = '0;
          vld_d[idx_q]  = 1'b1;
          state_d       = FINISH;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      FINISH: begin
        vld_d   = '0;
        err_d   = 1'b0;
        cs_n_d  = '1;
        last_d  = idx_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= IW'(N_REQ - 1);
      timer_q <= '0;
      err_q   <= 1'b0;
      cs_n_q  <= '1;
      vld_q   <= '0;
      dout_q  <= '0;
      mode_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      cs_n_q  <= cs_n_d;
      vld_q   <= vld_d;
      dout_q  <= dout_d;
      mode_q  <= mode_d;
      din_q   <= din_d;
    end
  end

  assign m_start_o   = (state_q == START);
  assign rsp_valid_o = vld_q;
  assign rsp_dout_o  = dout_q;
  assign rsp_err_o   = err_q;
  assign cs_n_o      = cs_n_q;
  assign m_mode_o    = mode_q;
  assign m_din_o     = din_q;

endmodule
